fir_decimator: RTL and testbench
================================

Name: fir_decimator

Overview:
- Downstream stage of the 16-tap moving-average FIR; consumes its registered N-bit output stream.
- Keeps one sample in every DECIM accepted samples, at a programmable phase.
- Buffers kept samples in a small show-ahead FIFO and presents them to a consumer over a valid/ready handshake.
- Overflow is flagged sticky when the consumer stalls.

Parameters:
- N, 16: sample width; matches FIR data width.
- DECIM, 4: decimation factor, ≥2.
- PHASE, 0: index (0..DECIM-1) of the kept sample within each group.
- DEPTH, 8: FIFO entries, power of 2, ≥2.
- AW, $clog2(DEPTH): FIFO address width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  input sample qualifier; tied high when fed directly by the FIR.
- in_data  in  N  FIR output sample.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  N  FIFO head (show-ahead).
- fill  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a kept sample was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (reset==0 at posedge) takes priority over all other inputs.
  - Phase counter, read/write pointers and fill go to 0; out_valid=0; overflow=0; out_data reads 0.
  - Reset mid-operation flushes the FIFO and restarts the group at count 0.
- Phase counter
  - Counts accepted inputs (in_valid==1) from 0 to DECIM-1, then wraps to 0.
  - Holds when in_valid==0.
  - keep = in_valid && (count==PHASE).
- Write
  - On keep, in_data is written at wr_ptr and wr_ptr advances (mod DEPTH).
  - Write is accepted if fill<DEPTH, or if fill==DEPTH and a read occurs in the same cycle.
  - Otherwise the sample is dropped, overflow is set, and pointers are unchanged.
- Read
  - rd = out_valid && out_ready.
  - On rd, rd_ptr advances; out_data is combinational mem[rd_ptr].
  - out_ready while empty has no effect.
  - out_valid = (fill!=0); fill updates only on posedge.
- Simultaneous read and write
  - fill is unchanged.
  - When empty, the write is taken and no read occurs (out_valid was 0).
- Latency
  - A sample kept at edge k is visible on out_valid/out_data after edge k.
  - End to end: DECIM inputs in, one output.
- overflow
  - Set on a drop; cleared by ovf_clr at posedge.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- Width rules: no arithmetic on samples; data passes bit-exact. fill arithmetic is AW+1 bits and never wraps.
- in_valid=0 for any number of cycles must not disturb buffered data or the phase.

Optional Feature:
- Macro FIR_DECIM_OVF_CNT_EN.
- Defined: adds output ovf_cnt [7:0].
  - Increments on each dropped sample and saturates at 255.
  - Cleared by reset or ovf_clr; increment wins over clear in the same cycle, giving 1.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package fir_pkg:
  - Sample width constant DATA_W=16.
  - Default DECIM and DEPTH constants.
  - Typedef sample_t (logic [DATA_W-1:0]).
- One natural sub-module, fir_sync_fifo: parameterised show-ahead FIFO with synchronous active-low reset, wr_en/rd_en, full/empty and fill.
- fir_decimator holds the phase counter, keep/drop logic and overflow flag.

Test Plan:
- Reset, then in_valid=1 with in_data=1,2,3,...,12 and out_ready=1 (DECIM=4, PHASE=0) -> outputs 1, 5, 9, each appearing the cycle after capture; fill never exceeds 1.
- PHASE=3, same stimulus -> outputs 4, 8, 12.
- out_ready=0, feed 40 samples (10 kept) -> fill saturates at 8 holding 1,5,...,29; overflow=1; 33 and 37 dropped. Then drain -> exactly 1..29 in order.
- FIFO full with out_ready=1 on the cycle a sample is kept -> head popped and new sample written, fill stays 8, overflow stays 0.
- Alternate in_valid 1/0 -> every 4th valid sample is kept, phase is not advanced by idle cycles. Pulse ovf_clr -> overflow clears.
- Assert reset=0 mid-stream with fill=5 -> next cycle fill=0, out_valid=0, overflow=0. First sample after release is kept (count restarts at 0).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output chain.
package fir_pkg;

  localparam int DATA_W    = 16;
  localparam int DECIM_DEF = 4;
  localparam int DEPTH_DEF = 8;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data presents the head combinationally,
// a write into a full FIFO is taken only when a read frees a slot in the
// same cycle. Synchronous active-low reset.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the empty gate on rd_data hides stale contents.
    if (reset && do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign fill    = count;

endmodule

// File: rtl/fir_decimator.sv
// Keeps one sample in every DECIM accepted inputs (at index PHASE), buffers
// kept samples in a show-ahead FIFO and flags a sticky overflow on drops.
// Optional macro FIR_DECIM_OVF_CNT_EN adds an 8-bit saturating drop counter.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DECIM = DECIM_DEF,
  parameter int PHASE = 0,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    overflow,
  input  logic                    ovf_clr
`ifdef FIR_DECIM_OVF_CNT_EN
  ,
  output logic [7:0]              ovf_cnt
`endif
);

  localparam int CW = $clog2(DECIM);

  logic [CW-1:0] phase_cnt;
  logic          keep;
  logic          rd;
  logic          wr_en;
  logic          drop;
  logic          full;
  logic          empty;

  // Decode keep / read / write / drop for this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    keep  = 1'b0;
    rd    = 1'b0;
    wr_en = 1'b0;
    drop  = 1'b0;
    keep  = in_valid && (phase_cnt == CW'(PHASE));
    rd    = !empty && out_ready;
    if (keep) begin
      if (!full || rd) wr_en = 1'b1;
      else             drop  = 1'b1;
    end
  end

  // Phase counter: advances only on accepted inputs, wraps after DECIM-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_cnt <= '0;
    end else if (in_valid) begin
      if (phase_cnt == CW'(DECIM - 1)) phase_cnt <= '0;
      else                             phase_cnt <= phase_cnt + CW'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef FIR_DECIM_OVF_CNT_EN
  // Saturating drop counter; a drop together with ovf_clr restarts it at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr)               ovf_cnt <= 8'd1;
      else if (ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end
  end
`endif

  fir_sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (rd),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty),
    .fill    (fill)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: PHASE=0 and PHASE=3 instances share stimulus.
module tb_fir_decimator;
  import fir_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  sample_t     in_data;
  logic        out_ready;
  logic        ovf_clr;

  logic        out_valid0, out_valid3;
  sample_t     out_data0, out_data3;
  logic [3:0]  fill0, fill3;
  logic        overflow0, overflow3;
`ifdef FIR_DECIM_OVF_CNT_EN
  logic [7:0]  ovf_cnt0, ovf_cnt3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fir_decimator #(.N(DATA_W), .DECIM(4), .PHASE(0), .DEPTH(8)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .fill      (fill0),
    .overflow  (overflow0),
    .ovf_clr   (ovf_clr)
`ifdef FIR_DECIM_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt0)
`endif
  );

  fir_decimator #(.N(DATA_W), .DECIM(4), .PHASE(3), .DEPTH(8)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out_data  (out_data3),
    .fill      (fill3),
    .overflow  (overflow3),
    .ovf_clr   (ovf_clr)
`ifdef FIR_DECIM_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    step();
    reset    = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    step();
    step();

    // Reset state.
    check("rst_out_valid", out_valid0, 0);
    check("rst_fill",      fill0,      0);
    check("rst_overflow",  overflow0,  0);
    check("rst_out_data",  out_data0,  0);

    // Streaming 1..12 with consumer ready: PHASE=0 keeps 1,5,9; PHASE=3 keeps 4,8,12.
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_data = sample_t'(i);
      step();
      check("p0_valid", out_valid0, ((i % 4) == 1) ? 1 : 0);
      if ((i % 4) == 1) check("p0_data", out_data0, i);
      check("p0_fill", fill0, ((i % 4) == 1) ? 1 : 0);
      check("p3_valid", out_valid3, ((i % 4) == 0) ? 1 : 0);
      if ((i % 4) == 0) check("p3_data", out_data3, i);
    end

    // Stalled consumer: 40 samples, 10 kept, 8 stored, 33 and 37 dropped.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      in_data = sample_t'(i);
      ovf_clr = (i == 37);
      step();
      if (i == 32) begin
        check("stall_fill_32", fill0,     8);
        check("stall_ovf_32",  overflow0, 0);
      end
      if (i == 33) begin
        check("stall_ovf_33",  overflow0, 1);
`ifdef FIR_DECIM_OVF_CNT_EN
        check("ovf_cnt_33",    ovf_cnt0,  1);
`endif
      end
      if (i == 37) begin
        check("ovf_set_wins",  overflow0, 1);
`ifdef FIR_DECIM_OVF_CNT_EN
        check("ovf_cnt_inc_wins", ovf_cnt0, 1);
`endif
      end
    end
    ovf_clr = 1'b0;
    check("stall_fill", fill0,     8);
    check("stall_head", out_data0, 1);

    // Drain: exactly 1,5,...,29 in order.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", out_valid0, 1);
      check("drain_data",  out_data0,  1 + 4 * k);
      step();
    end
    check("drain_empty",     out_valid0, 0);
    check("drain_fill",      fill0,      0);
    check("drain_ovf_stick", overflow0,  1);

    // ovf_clr pulse clears the flag.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow0, 0);
`ifdef FIR_DECIM_OVF_CNT_EN
    check("ovf_cnt_clr", ovf_cnt0, 0);
`endif

    // Full FIFO with a read on the keep cycle: no drop, fill stays 8.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = sample_t'(200 + i);
      step();
    end
    check("full_fill",     fill0,     8);
    check("full_overflow", overflow0, 0);
    in_data   = sample_t'(232);
    out_ready = 1'b1;
    step();
    check("rw_full_fill", fill0,     8);
    check("rw_full_ovf",  overflow0, 0);
    check("rw_full_head", out_data0, 204);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("rw_drain_data", out_data0, 204 + 4 * k);
      step();
    end
    check("rw_drain_empty", out_valid0, 0);

    // Alternating in_valid: idle cycles do not advance the phase.
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      in_valid = ((j % 2) == 0);
      in_data  = sample_t'(300 + j);
      step();
      check("alt_valid", out_valid0, (j == 0 || j == 8) ? 1 : 0);
      if (j == 0 || j == 8) check("alt_data", out_data0, 300 + j);
    end

    // Reset mid-stream with fill=5 and the phase mid-group.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_data = sample_t'(400 + i);
      step();
    end
    check("pre_rst_fill", fill0, 5);
    reset   = 1'b0;
    in_data = sample_t'(999);
    step();
    check("mid_rst_fill",     fill0,      0);
    check("mid_rst_valid",    out_valid0, 0);
    check("mid_rst_overflow", overflow0,  0);
    check("mid_rst_data",     out_data0,  0);
    reset   = 1'b1;
    in_data = sample_t'(777);
    step();
    check("post_rst_valid", out_valid0, 1);
    check("post_rst_data",  out_data0,  777);
    check("post_rst_fill",  fill0,      1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
